// File: rtl/uart_prog_loader_if.sv
// Byte-in / word-write-out bundle between UART_rx, the program loader and the
// on-chip memories. "master" is the side that feeds bytes and watches the
// write port (UART_rx plus memory/core), "slave" is the loader itself.
interface uart_prog_loader_if #(
    parameter int ADDR_W      = 14,
    parameter int WORD_BYTES  = 2,
    parameter int NUM_TARGETS = 2
);
    logic [7:0]              rx_data;
    logic                    rdy;
    logic                    clr_rdy;
    logic                    we;
    logic [NUM_TARGETS-1:0]  wsel;
    logic [ADDR_W-1:0]       waddr;
    logic [8*WORD_BYTES-1:0] wdata;
    logic                    busy;
    logic                    go;
    logic [2:0]              err;

    modport master (
        output rx_data, rdy,
        input  clr_rdy, we, wsel, waddr, wdata, busy, go, err
    );

    modport slave (
        input  rx_data, rdy,
        output clr_rdy, we, wsel, waddr, wdata, busy, go, err
    );
endinterface

// File: rtl/uart_prog_loader.sv
// Packet-based program/data loader.
// Frame: SYNC, target, address (little-endian, ceil(ADDR_W/8) bytes),
// word count (2 bytes LE), payload (count*WORD_BYTES bytes LE), and a
// trailing checksum byte when LOADER_CKSUM_EN is defined.
// A frame with word count 0 is a GO frame: it raises the sticky run enable.
// err = {checksum, timeout, bad_target}, cleared by each SYNC.
module uart_prog_loader #(
    parameter int         ADDR_W         = 14,
    parameter int         WORD_BYTES     = 2,
    parameter int         ADDR_STEP      = 2,
    parameter int         NUM_TARGETS    = 2,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input logic               clk,
    input logic               rst_n,
    uart_prog_loader_if.slave bus
);
    localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
    localparam int WORD_BITS  = 8 * WORD_BYTES;
    localparam int TMO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TGT   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_LEN   = 3'd3,
        ST_DATA  = 3'd4,
        ST_CKSUM = 3'd5
    } state_e;

    // State entered after the last length/payload byte.
`ifdef LOADER_CKSUM_EN
    localparam state_e ST_TAIL = ST_CKSUM;
`else
    localparam state_e ST_TAIL = ST_IDLE;
`endif

    function automatic logic [NUM_TARGETS-1:0] onehot_f(input logic [7:0] tgt);
        onehot_f = {{(NUM_TARGETS-1){1'b0}}, 1'b1} << tgt;
    endfunction

    function automatic logic [7:0] sum8_f(input logic [7:0] a, input logic [7:0] b);
        sum8_f = a + b;
    endfunction

    state_e                  state_q, state_d;
    logic                    clr_rdy_q, clr_rdy_d;
    logic                    we_q, we_d;
    logic [NUM_TARGETS-1:0]  wsel_q, wsel_d;
    logic [ADDR_W-1:0]       waddr_q, waddr_d;
    logic [WORD_BITS-1:0]    wdata_q, wdata_d;
    logic                    busy_q, busy_d;
    logic                    go_q, go_d;
    logic [2:0]              err_q, err_d;
    logic [7:0]              tgt_q, tgt_d;
    logic [7:0]              idx_q, idx_d;
    logic [ADDR_W-1:0]       hdr_q, hdr_d;
    logic [7:0]              len_lo_q, len_lo_d;
    logic [15:0]             words_q, words_d;
    logic [WORD_BITS-1:0]    word_q, word_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
`ifdef LOADER_CKSUM_EN
    logic [7:0]              sum_q, sum_d;
    logic                    is_go_q, is_go_d;
`endif

    logic                    acc_s;
    logic                    tmo_hit_s;
    logic                    addr_last_s;
    logic                    len_last_s;
    logic                    word_last_s;
    logic                    words_last_s;
    logic [ADDR_W-1:0]       addr_new_s;
    logic [15:0]             len_new_s;
    logic [WORD_BITS-1:0]    word_new_s;

    // The clr_rdy pulse masks rdy for one cycle, so each byte is taken once.
    assign acc_s        = bus.rdy & ~clr_rdy_q;
    assign tmo_hit_s    = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_W'(TIMEOUT_CYCLES)) && !acc_s;
    assign addr_last_s  = (idx_q == 8'(ADDR_BYTES - 1));
    assign len_last_s   = (idx_q == 8'd1);
    assign word_last_s  = (idx_q == 8'(WORD_BYTES - 1));
    assign words_last_s = (words_q == 16'd1);
    // Little-endian assembly; address bits beyond ADDR_W fall off the shift.
    assign addr_new_s   = hdr_q | (ADDR_W'(bus.rx_data) << {idx_q, 3'b000});
    assign len_new_s    = {bus.rx_data, len_lo_q};
    assign word_new_s   = word_q | (WORD_BITS'(bus.rx_data) << {idx_q, 3'b000});

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: advance on accepted bytes, timeout aborts to IDLE.
    always_comb begin
        state_d = state_q;
        if (tmo_hit_s) begin
            state_d = ST_IDLE;
        end else if (acc_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (!go_q && (bus.rx_data == SYNC_BYTE)) begin
                        state_d = ST_TGT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_TGT:  state_d = ST_ADDR;
                ST_ADDR: begin
                    if (addr_last_s) begin
                        state_d = ST_LEN;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
                ST_LEN: begin
                    if (len_last_s) begin
                        state_d = (len_new_s == 16'd0) ? ST_TAIL : ST_DATA;
                    end else begin
                        state_d = ST_LEN;
                    end
                end
                ST_DATA: begin
                    if (word_last_s && words_last_s) begin
                        state_d = ST_TAIL;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
`ifdef LOADER_CKSUM_EN
                ST_CKSUM: state_d = ST_IDLE;
`endif
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM outputs and datapath next values (all outputs are registered).
    always_comb begin
        clr_rdy_d = acc_s;
        we_d      = 1'b0;
        wsel_d    = {NUM_TARGETS{1'b0}};
        waddr_d   = we_q ? (waddr_q + ADDR_W'(ADDR_STEP)) : waddr_q;
        wdata_d   = wdata_q;
        busy_d    = (state_d != ST_IDLE);
        go_d      = go_q;
        err_d     = err_q;
        tgt_d     = tgt_q;
        idx_d     = idx_q;
        hdr_d     = hdr_q;
        len_lo_d  = len_lo_q;
        words_d   = words_q;
        word_d    = word_q;
`ifdef LOADER_CKSUM_EN
        sum_d     = (acc_s && (state_q != ST_IDLE)) ? sum8_f(sum_q, bus.rx_data) : sum_q;
        is_go_d   = is_go_q;
`endif

        // Timeout counter: cleared by any accepted byte, runs while busy.
        if (acc_s || tmo_hit_s) begin
            tmo_d = {TMO_W{1'b0}};
        end else if ((state_q != ST_IDLE) && (TIMEOUT_CYCLES != 0)) begin
            tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end else begin
            tmo_d = {TMO_W{1'b0}};
        end

        if (tmo_hit_s) begin
            err_d[1] = 1'b1;
            idx_d    = 8'd0;
            word_d   = {WORD_BITS{1'b0}};
        end else if (acc_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (!go_q && (bus.rx_data == SYNC_BYTE)) begin
                        err_d  = 3'b000;
                        idx_d  = 8'd0;
                        hdr_d  = {ADDR_W{1'b0}};
                        word_d = {WORD_BITS{1'b0}};
`ifdef LOADER_CKSUM_EN
                        sum_d   = 8'd0;
                        is_go_d = 1'b0;
`endif
                    end else begin
                        err_d = err_q;
                    end
                end
                ST_TGT: begin
                    tgt_d = bus.rx_data;
                    if (int'(bus.rx_data) >= NUM_TARGETS) begin
                        err_d[0] = 1'b1;
                    end else begin
                        err_d[0] = err_q[0];
                    end
                end
                ST_ADDR: begin
                    if (addr_last_s) begin
                        idx_d   = 8'd0;
                        waddr_d = addr_new_s;
                    end else begin
                        idx_d = idx_q + 8'd1;
                        hdr_d = addr_new_s;
                    end
                end
                ST_LEN: begin
                    if (len_last_s) begin
                        idx_d   = 8'd0;
                        words_d = len_new_s;
                        if (len_new_s == 16'd0) begin
`ifdef LOADER_CKSUM_EN
                            is_go_d = 1'b1;
`else
                            go_d = !err_q[0];
`endif
                        end else begin
                            go_d = go_q;
                        end
                    end else begin
                        idx_d    = idx_q + 8'd1;
                        len_lo_d = bus.rx_data;
                    end
                end
                ST_DATA: begin
                    if (word_last_s) begin
                        idx_d   = 8'd0;
                        word_d  = {WORD_BITS{1'b0}};
                        words_d = words_q - 16'd1;
                        if (!err_q[0]) begin
                            we_d    = 1'b1;
                            wsel_d  = onehot_f(tgt_q);
                            wdata_d = word_new_s;
                        end else begin
                            we_d = 1'b0;
                        end
                    end else begin
                        idx_d  = idx_q + 8'd1;
                        word_d = word_new_s;
                    end
                end
`ifdef LOADER_CKSUM_EN
                ST_CKSUM: begin
                    if (sum8_f(sum_q, bus.rx_data) != 8'd0) begin
                        err_d[2] = 1'b1;
                    end else if (is_go_q && !err_q[0]) begin
                        go_d = 1'b1;
                    end else begin
                        go_d = go_q;
                    end
                end
`endif
                default: begin
                    idx_d = 8'd0;
                end
            endcase
        end else begin
            idx_d = idx_q;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_rdy_q <= 1'b0;
            we_q      <= 1'b0;
            wsel_q    <= {NUM_TARGETS{1'b0}};
            waddr_q   <= {ADDR_W{1'b0}};
            wdata_q   <= {WORD_BITS{1'b0}};
            busy_q    <= 1'b0;
            go_q      <= 1'b0;
            err_q     <= 3'b000;
            tgt_q     <= 8'd0;
            idx_q     <= 8'd0;
            hdr_q     <= {ADDR_W{1'b0}};
            len_lo_q  <= 8'd0;
            words_q   <= 16'd0;
            word_q    <= {WORD_BITS{1'b0}};
            tmo_q     <= {TMO_W{1'b0}};
`ifdef LOADER_CKSUM_EN
            sum_q     <= 8'd0;
            is_go_q   <= 1'b0;
`endif
        end else begin
            clr_rdy_q <= clr_rdy_d;
            we_q      <= we_d;
            wsel_q    <= wsel_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            go_q      <= go_d;
            err_q     <= err_d;
            tgt_q     <= tgt_d;
            idx_q     <= idx_d;
            hdr_q     <= hdr_d;
            len_lo_q  <= len_lo_d;
            words_q   <= words_d;
            word_q    <= word_d;
            tmo_q     <= tmo_d;
`ifdef LOADER_CKSUM_EN
            sum_q     <= sum_d;
            is_go_q   <= is_go_d;
`endif
        end
    end

    assign bus.clr_rdy = clr_rdy_q;
    assign bus.we      = we_q;
    assign bus.wsel    = wsel_q;
    assign bus.waddr   = waddr_q;
    assign bus.wdata   = wdata_q;
    assign bus.busy    = busy_q;
    assign bus.go      = go_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: directed and random frames checked against a
// frame-level model (expected write list, error bits, run enable).
module tb_uart_prog_loader;
    localparam int         AW   = 14;
    localparam int         WB   = 2;
    localparam int         STEP = 2;
    localparam int         NT   = 2;
    localparam int         TMO  = 200;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef LOADER_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_prog_loader_if #(.ADDR_W(AW), .WORD_BYTES(WB), .NUM_TARGETS(NT)) bus ();

    uart_prog_loader #(
        .ADDR_W(AW), .WORD_BYTES(WB), .ADDR_STEP(STEP), .NUM_TARGETS(NT),
        .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          clr_cnt  = 0;
    int          last_nbytes = 0;
    logic [31:0] exp_q[$];
    logic [31:0] act_q[$];
    logic [2:0]  exp_err = 3'b000;
    logic        exp_go  = 1'b0;
    logic [15:0] pl [0:7];

    // Monitor: count consume pulses, log every write (or stray wsel).
    always @(negedge clk) begin
        if (bus.clr_rdy) clr_cnt <= clr_cnt + 1;
        if (bus.we || (bus.wsel != 2'b00)) act_q.push_back({bus.wsel, bus.waddr, bus.wdata});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and wait (bounded) for its consume pulse.
    task automatic send_byte(input logic [7:0] b, input bit hold);
        bit got;
        got = 1'b0;
        if (!hold) repeat ($urandom_range(0, 2)) tick();
        bus.rx_data = b;
        bus.rdy     = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (bus.clr_rdy) got = 1'b1;
        end
        if (!hold) bus.rdy = 1'b0;
        if (!got) chk("byte_accept", 32'(got), 32'd1);
    endtask

    // Build a frame from pl[], update the model, and send it.
    task automatic send_packet(input logic [7:0] t, input logic [13:0] a, input int nw,
                               input bit bad_ck, input bit hold, input bit nosync);
        logic [7:0]  bq[$];
        logic [7:0]  s;
        logic [15:0] n16;
        logic [13:0] wa;
        logic        gone;
        gone = exp_go;
        n16  = 16'(nw);
        if (!nosync) bq.push_back(SYNC);
        bq.push_back(t);
        bq.push_back(a[7:0]);
        bq.push_back({2'b00, a[13:8]});
        bq.push_back(n16[7:0]);
        bq.push_back(n16[15:8]);
        for (int i = 0; i < nw; i++) begin
            bq.push_back(pl[i][7:0]);
            bq.push_back(pl[i][15:8]);
        end
        if (CK) begin
            s = 8'd0;
            for (int i = (nosync ? 0 : 1); i < bq.size(); i++) s = s + bq[i];
            s = 8'd0 - s;
            if (bad_ck) s = s + 8'd1;
            bq.push_back(s);
        end
        if (!gone) begin
            exp_err = {CK && bad_ck, 1'b0, (int'(t) >= NT)};
            if (int'(t) < NT) begin
                for (int i = 0; i < nw; i++) begin
                    wa = a + 14'(STEP * i);
                    exp_q.push_back({2'(1 << t), wa, pl[i]});
                end
            end
            if (nw == 0 && exp_err == 3'b000) exp_go = 1'b1;
        end
        last_nbytes = bq.size();
        for (int i = 0; i < bq.size() - 1; i++) send_byte(bq[i], hold);
        chk("go_before_last", 32'(bus.go), 32'(gone));
        send_byte(bq[bq.size() - 1], hold);
        bus.rdy = 1'b0;
        chk("go_at_last", 32'(bus.go), 32'(exp_go));
    endtask

    // Settle, then compare writes, error bits, go and busy with the model.
    task automatic check_pkt(input string tag);
        repeat (3) tick();
        chk({tag, "_nwr"}, 32'(act_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && act_q.size() > 0)
            chk({tag, "_wr"}, act_q.pop_front(), exp_q.pop_front());
        act_q.delete();
        exp_q.delete();
        chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        chk({tag, "_go"}, 32'(bus.go), 32'(exp_go));
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int c0;
        int k;
        bus.rx_data = 8'h00;
        bus.rdy     = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_bus", {bus.wsel, bus.waddr, bus.wdata}, 32'd0);
        chk("rst_ctl", 32'({bus.clr_rdy, bus.we, bus.busy, bus.go, bus.err}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed load: 0x0010 <- 1234, 0x0012 <- 5678 on target 0
        pl[0] = 16'h1234; pl[1] = 16'h5678;
        send_packet(8'h00, 14'h0010, 2, 1'b0, 1'b0, 1'b0);
        check_pkt("load1");

`ifdef LOADER_CKSUM_EN
        // Bad checksum: writes still happen, err[2]; bad-checksum GO keeps go low
        send_packet(8'h00, 14'h0010, 2, 1'b1, 1'b0, 1'b0);
        check_pkt("bad_ck_load");
        send_packet(8'h00, 14'h0000, 0, 1'b1, 1'b0, 1'b0);
        check_pkt("bad_ck_go");
`endif

        // Out-of-range target: no writes, err[0]
        pl[0] = 16'hAAAA; pl[1] = 16'h5555;
        send_packet(8'h05, 14'h0020, 2, 1'b0, 1'b0, 1'b0);
        check_pkt("bad_tgt");

        // Timeout after SYNC + target, then SYNC clears err
        send_byte(SYNC, 1'b0);
        send_byte(8'h00, 1'b0);
        exp_err = 3'b010;
        repeat (TMO - 20) tick();
        chk("tmo_busy_early", 32'(bus.busy), 32'd1);
        k = 0;
        while (bus.busy && k < 60) begin
            tick();
            k++;
        end
        chk("tmo_busy_fall", 32'(bus.busy), 32'd0);
        chk("tmo_err", 32'(bus.err), 32'(exp_err));
        chk("tmo_nwr", 32'(act_q.size()), 32'd0);
        send_byte(SYNC, 1'b0);
        chk("sync_clr_err", 32'(bus.err), 32'd0);
        chk("sync_busy", 32'(bus.busy), 32'd1);
        pl[0] = 16'hBEEF;
        send_packet(8'h00, 14'h0100, 1, 1'b0, 1'b0, 1'b1);
        check_pkt("after_tmo");

        // Garbage in IDLE is consumed and dropped
        c0 = clr_cnt;
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h5A, 1'b0);
        repeat (2) tick();
        chk("garbage_clr", 32'(clr_cnt - c0), 32'd3);
        chk("garbage_busy", 32'(bus.busy), 32'd0);
        pl[0] = 16'h1234; pl[1] = 16'h5678;
        send_packet(8'h01, 14'h0010, 2, 1'b0, 1'b0, 1'b0);
        check_pkt("load_after_garbage");

        // Same with rdy held high throughout: one consume pulse per byte
        c0 = clr_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_packet(8'h01, 14'h0010, 2, 1'b0, 1'b1, 1'b0);
        check_pkt("hold_load");
        chk("hold_clr", 32'(clr_cnt - c0), 32'(3 + last_nbytes));

        // Random frames (first one wraps the address space)
        for (int r = 0; r < 6; r++) begin
            logic [7:0]  t;
            logic [13:0] a;
            int          nw;
            t  = ($urandom_range(0, 3) == 0) ? 8'd2 : 8'($urandom_range(0, 1));
            a  = (r == 0) ? 14'h3FFE : 14'($urandom);
            nw = (r == 0) ? 3 : $urandom_range(1, 4);
            for (int i = 0; i < nw; i++) pl[i] = 16'($urandom);
            send_packet(t, a, nw, CK && ($urandom_range(0, 3) == 0), r[0], 1'b0);
            check_pkt("rnd");
        end

        // Reset mid-frame
        send_byte(SYNC, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0);
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", 32'({bus.clr_rdy, bus.we, bus.busy, bus.go, bus.err}), 32'd0);
        chk("mid_rst_bus", {bus.wsel, bus.waddr, bus.wdata}, 32'd0);
        exp_err = 3'b000;
        exp_go  = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        pl[0] = 16'h0F0F; pl[1] = 16'hF0F0;
        send_packet(8'h01, 14'h0200, 2, 1'b0, 1'b0, 1'b0);
        check_pkt("after_mid_rst");

        // GO frame, then further frames are consumed and ignored
        send_packet(8'h00, 14'h0000, 0, 1'b0, 1'b0, 1'b0);
        check_pkt("go");
        c0 = clr_cnt;
        pl[0] = 16'h1111; pl[1] = 16'h2222;
        send_packet(8'h00, 14'h0040, 2, 1'b0, 1'b1, 1'b0);
        check_pkt("ignored");
        chk("ignored_clr", 32'(clr_cnt - c0), 32'(last_nbytes));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
Packet-based program/data loader between the existing byte-level UART_rx and one or more on-chip memories (imem, dmem, ...). It parses framed packets: sync, target, start address, word count, payload, optional checksum. It issues word-wide write strobes to the selected target and raises a level "go" that releases the processor from reset. It generalises the fixed two-byte, single-memory, magic-word loader in the top level: configurable word width, address width, address step and target count, plus error detection and an inter-byte timeout.

Parameters:
ADDR_W, 14, width of waddr; address bytes in header = ceil(ADDR_W/8), little-endian, excess bits dropped
WORD_BYTES, 2, bytes per payload word, little-endian; wdata width = 8*WORD_BYTES
ADDR_STEP, 2, amount waddr advances after each word write
NUM_TARGETS, 2, number of write-select lines (target byte 0..NUM_TARGETS-1 valid)
SYNC_BYTE, 8'hA5, packet start byte
TIMEOUT_CYCLES, 50000, idle cycles tolerated mid-packet; 0 disables timeout

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
rx_data  in  8  byte from UART_rx
rdy  in  1  UART_rx byte valid (level)
clr_rdy  out  1  one-cycle consume pulse to UART_rx
we  out  1  one-cycle word write strobe
wsel  out  NUM_TARGETS  one-hot target select, valid with we
waddr  out  ADDR_W  word write address
wdata  out  8*WORD_BYTES  word write data
busy  out  1  high in any state other than IDLE
go  out  1  processor run enable (level)
err  out  3  sticky {cksum, timeout, bad_target}

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Byte accept: when rdy & ~clr_rdy at a clock edge. clr_rdy is high for exactly the next cycle, so a byte is never consumed twice.
- States: IDLE -> TGT -> ADDR (ADDR_BYTES bytes) -> LEN (2 bytes, LE, word count) -> DATA (count*WORD_BYTES bytes) -> CKSUM (macro only) -> IDLE.
- IDLE: non-SYNC bytes are consumed and discarded. SYNC clears err and goes to TGT.
- TGT: target >= NUM_TARGETS sets err[0]. The packet is still parsed to completion, but we stays 0 and go is not asserted.
- LEN = 0: skip DATA. This is a GO packet. On completion with no error set during the packet, go rises the cycle after the final byte accept.
- go is a level. Once high it holds until rst_n. While go=1, bytes are still consumed but ignored (state stays IDLE).
- Write timing:
  - The last byte of a word is accepted at edge N. During cycle N+1: we=1, wsel=onehot(target), wdata = full word, waddr = current address.
  - waddr += ADDR_STEP at the end of that cycle, wrapping modulo 2^ADDR_W.
  - waddr is loaded from the header at the end of the ADDR state.
  - Only full words are written; when not writing, wsel=0.
- Timeout: a counter clears on every byte accept and counts while busy. When it reaches TIMEOUT_CYCLES: err[1] set, state -> IDLE, partial word dropped. A byte accept in the same cycle wins over the timeout.
- A non-LEN=0 packet never asserts go. Writes already issued are not rolled back on a later error.
- Reset mid-packet: immediate return to IDLE, all outputs 0.

Optional Feature:
- Macro LOADER_CKSUM_EN.
- Defined: after the payload (or after LEN when count=0), one checksum byte is expected. The 8-bit sum of every byte from target through checksum inclusive must be 8'h00; otherwise err[2] is set and go is suppressed.
- Undefined: no checksum byte; the packet ends after the last payload byte (or after LEN for a GO packet); err[2] is tied 0.

Test Plan:
- Defaults, macro on. Bytes A5 00 10 00 02 00 34 12 78 56 DA -> two we pulses: waddr 0x0010/wdata 0x1234, then 0x0012/0x5678. wsel=2'b01, err=0, go=0.
- After load, GO packet A5 00 00 00 00 00 00 -> go=1 one cycle after last accept. Subsequent bytes consumed via clr_rdy, no we.
- Same load but checksum DB -> both writes occur, err=3'b100. A following GO packet with bad checksum leaves go=0.
- Target byte 05 (NUM_TARGETS=2), valid checksum -> no we for whole packet, err=3'b001.
- A5 00 then silence for TIMEOUT_CYCLES -> busy falls, err=3'b010. Next A5 clears err to 0.
- Garbage 00 FF 5A in IDLE, then a valid load packet -> garbage discarded (3 clr_rdy pulses), packet writes correctly. Repeat with rdy held high continuously: exactly one clr_rdy per byte.
